// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Moore sequencer for a shared-memory, single-ALU multicycle RV32I datapath.
// It supports lw, sw, R-type, I-type ALU, beq and jal. The sequencer steps once
// per clock. The memory-access steps (FETCH, MEMREAD, MEMWRITE) stretch while
// mem_ready is low.
//
// Parameters:
//   WAIT_MEM  1 = honour mem_ready, 0 = treat mem_ready as always 1
//   CNT_W     width of the optional performance counters
//
// Ports:
//   clk, srst          clock, synchronous active-high reset
//   opcode, funct3,    latched instruction fields from the instruction register
//   funct7b5
//   zero               ALU zero flag (beq)
//   mem_ready          memory completes the access this cycle
//   mem_req, adr_src   memory request, address select (0 PC, 1 ALUOut)
//   ir_write, pc_write instruction register / PC load enables
//   mem_w, reg_w       data memory write, register file write
//   result_src         00 ALUOut, 01 Data, 10 ALU result
//   alu_src_a          00 PC, 01 OldPC, 10 RD1
//   alu_src_b          00 RD2, 01 ImmExt, 10 const 4
//   imm_src            00 I, 01 S, 10 B, 11 J (combinational from opcode)
//   alu_control        000 add, 001 sub, 010 and, 011 or, 101 slt
//   illegal            sticky illegal-opcode flag
//   state              current state encoding, for debug
//
// Optional feature, enabled with `define MULTICYCLE_CTRL_PERF_EN:
//   cycle_cnt          counts every cycle with srst=0
//   instret_cnt        counts retired instructions
//   Both counters are cleared by srst and wrap modulo 2^CNT_W.
module multicycle_ctrl #(
  parameter int WAIT_MEM = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             mem_w,
  output logic             reg_w,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic [2:0]       alu_control,
  output logic             illegal,
  output logic [3:0]       state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_reg;
  state_t     state_next;
  logic       illegal_reg;
  logic       ready;
  logic [2:0] funct_alu;

  // With WAIT_MEM=0 the memory is assumed to be single-cycle.
  assign ready = (WAIT_MEM == 0) ? 1'b1 : mem_ready;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (ready) state_next = S_MEMWB;
      S_MEMWRITE: if (ready) state_next = S_FETCH;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_next = S_ALUWB;
      S_MEMWB,
      S_ALUWB,
      S_BEQ:      state_next = S_FETCH;
      S_ILLEGAL:  state_next = S_ILLEGAL;
      // Unused encodings fall back to FETCH.
      default:    state_next = S_FETCH;
    endcase
  end

  // State and sticky illegal flag. The flag is set on entry to ILLEGAL, so it
  // is high in the same cycles in which the state reads ILLEGAL.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == S_ILLEGAL) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  // ALU operation for the EXECR/EXECI steps. opcode[5] separates R-type from
  // I-type, so addi with imm[10]=1 is never mistaken for sub.
  always_comb begin
    case (funct3)
      3'b000:  funct_alu = (opcode[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_alu = ALU_SLT;
      3'b110:  funct_alu = ALU_OR;
      3'b111:  funct_alu = ALU_AND;
      default: funct_alu = ALU_ADD;
    endcase
  end

  // The immediate format depends only on the opcode, not on the state.
  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Per-state output decode. Only the FETCH enables and the beq PC write look
  // at live inputs (mem_ready, zero); everything else is a function of state.
  always_comb begin
    mem_req     = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    mem_w       = 1'b0;
    reg_w       = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    case (state_reg)
      S_FETCH: begin
        // PC+4 goes straight from the ALU to the PC.
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = ready;
        pc_write   = ready;
      end
      S_DECODE: begin
        // OldPC + imm: the branch target lands in ALUOut for BEQ.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = funct_alu;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
      end
      S_BEQ: begin
        // ALUOut still holds the target from DECODE; result_src=00 selects it.
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_write    = zero;
      end
      S_JAL: begin
        // Link value OldPC+4 is computed here; the target from DECODE is loaded.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign illegal = illegal_reg;
  assign state   = state_reg;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_reg;
  logic [CNT_W-1:0] instret_cnt_reg;
  logic             retire;

  // An instruction retires when its last step hands control back to FETCH.
  assign retire = (state_next == S_FETCH) &&
                  ((state_reg == S_MEMWB) || (state_reg == S_MEMWRITE) ||
                   (state_reg == S_ALUWB) || (state_reg == S_BEQ));

  always_ff @(posedge clk) begin
    if (srst) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
      if (retire) begin
        instret_cnt_reg <= instret_cnt_reg + 1'b1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. A per-instruction model expands each
// instruction into its expected sequence of cycles. A single compare process
// checks every cycle against it. Literal pins at chosen cycles anchor the
// model to hand-computed values.
module tb_multicycle_ctrl;

  localparam int TB_CNT_W = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  localparam int SEL_STATE = 0, SEL_IRW = 1, SEL_PCW = 2, SEL_SRCB = 3,
                 SEL_ILL = 4, SEL_ALU = 5, SEL_REGW = 6, SEL_RES = 7,
                 SEL_INST = 8;

  logic       clk = 1'b0;
  logic       srst, funct7b5, zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_req, adr_src, ir_write, pc_write, mem_w, reg_w, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [TB_CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl #(.WAIT_MEM(1), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .srst(srst), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .mem_w(mem_w), .reg_w(reg_w),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
    .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req, adr_src, ir_write, pc_write, mem_w, reg_w;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       illegal;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
    int   inst;
  } exp_rec_t;

  typedef struct {
    string name;
    int    idx;
    int    sel;
    int    want;
  } pin_t;

  exp_rec_t exp_q[$];
  pin_t     pin_q[$];
  vec_t     trace[$];
  int       trace_inst[$];
  int       checks = 0;
  int       passes = 0;
  int       ncyc   = 0;
  int       cyc_m  = 0;
  int       inst_m = 0;

  // ---------------- model ----------------
  function automatic logic [1:0] exp_imm(input logic [6:0] op);
    if (op == SW)  return 2'b01;
    if (op == BEQ) return 2'b10;
    if (op == JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (op == RT && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic vec_t vbase(input logic [3:0] st);
    vec_t v;
    v = '0;
    v.state   = st;
    v.imm_src = exp_imm(opcode);
    return v;
  endfunction

  function automatic vec_t v_fetch(input logic rdy);
    vec_t v;
    v = vbase(4'd0);
    v.mem_req    = 1'b1;
    v.alu_src_b  = 2'b10;
    v.result_src = 2'b10;
    v.ir_write   = rdy;
    v.pc_write   = rdy;
    return v;
  endfunction

  function automatic vec_t v_mem(input logic [3:0] st, input logic wr);
    vec_t v;
    v = vbase(st);
    v.mem_req = 1'b1;
    v.adr_src = 1'b1;
    v.mem_w   = wr;
    return v;
  endfunction

  function automatic vec_t v_ill();
    vec_t v;
    v = vbase(4'd11);
    v.illegal = 1'b1;
    return v;
  endfunction

  function automatic int fld(input vec_t v, input int sel);
    case (sel)
      SEL_STATE: return int'(v.state);
      SEL_IRW:   return int'(v.ir_write);
      SEL_PCW:   return int'(v.pc_write);
      SEL_SRCB:  return int'(v.alu_src_b);
      SEL_ILL:   return int'(v.illegal);
      SEL_ALU:   return int'(v.alu_control);
      SEL_REGW:  return int'(v.reg_w);
      SEL_RES:   return int'(v.result_src);
      default:   return -1;
    endcase
  endfunction

  // One clock cycle: drive inputs, record what the DUT must show, advance.
  task automatic cyc(input vec_t v, input logic mr, input logic z,
                     input logic rst, input logic retire);
    exp_rec_t r;
    mem_ready = mr;
    zero      = z;
    srst      = rst;
    r.v = v; r.cyc = cyc_m; r.inst = inst_m;
    exp_q.push_back(r);
    ncyc++;
    @(posedge clk); #1;
    if (rst) begin
      cyc_m = 0; inst_m = 0;
    end else begin
      cyc_m++;
      if (retire) inst_m++;
    end
  endtask

  task automatic pin(input string n, input int idx, input int sel, input int want);
    pin_t p;
    p.name = n; p.idx = idx; p.sel = sel; p.want = want;
    pin_q.push_back(p);
  endtask

  // wf = FETCH wait cycles, wm = MEMREAD/MEMWRITE wait cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int wf, input int wm);
    vec_t v;
    opcode = op; funct3 = f3; funct7b5 = f7;
    for (int i = 0; i < wf; i++) cyc(v_fetch(1'b0), 1'b0, z, 1'b0, 1'b0);
    cyc(v_fetch(1'b1), 1'b1, z, 1'b0, 1'b0);
    v = vbase(4'd1); v.alu_src_a = 2'b01; v.alu_src_b = 2'b01;
    cyc(v, 1'b0, z, 1'b0, 1'b0);
    if (op == LW || op == SW) begin
      v = vbase(4'd2); v.alu_src_a = 2'b10; v.alu_src_b = 2'b01;
      cyc(v, 1'b0, z, 1'b0, 1'b0);
      if (op == LW) begin
        for (int i = 0; i < wm; i++) cyc(v_mem(4'd3, 1'b0), 1'b0, z, 1'b0, 1'b0);
        cyc(v_mem(4'd3, 1'b0), 1'b1, z, 1'b0, 1'b0);
        v = vbase(4'd4); v.result_src = 2'b01; v.reg_w = 1'b1;
        cyc(v, 1'b0, z, 1'b0, 1'b1);
      end else begin
        for (int i = 0; i < wm; i++) cyc(v_mem(4'd5, 1'b1), 1'b0, z, 1'b0, 1'b0);
        cyc(v_mem(4'd5, 1'b1), 1'b1, z, 1'b0, 1'b1);
      end
    end else if (op == RT || op == IT) begin
      v = vbase(op == RT ? 4'd6 : 4'd7);
      v.alu_src_a   = 2'b10;
      v.alu_src_b   = (op == RT) ? 2'b00 : 2'b01;
      v.alu_control = exp_alu(op, f3, f7);
      cyc(v, 1'b0, z, 1'b0, 1'b0);
      v = vbase(4'd8); v.reg_w = 1'b1;
      cyc(v, 1'b1, z, 1'b0, 1'b1);
    end else if (op == BEQ) begin
      v = vbase(4'd9); v.alu_src_a = 2'b10; v.alu_control = 3'b001; v.pc_write = z;
      cyc(v, 1'b0, z, 1'b0, 1'b1);
    end else if (op == JAL) begin
      v = vbase(4'd10); v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.pc_write = 1'b1;
      cyc(v, 1'b0, z, 1'b0, 1'b0);
      v = vbase(4'd8); v.reg_w = 1'b1;
      cyc(v, 1'b0, z, 1'b0, 1'b1);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_rec_t r;
    vec_t     got;
    pin_t     p;
    int       act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        r   = exp_q.pop_front();
        got = {state, mem_req, adr_src, ir_write, pc_write, mem_w, reg_w,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};
        checks++;
        if (got !== r.v)
          $display("FAIL cycle%0d outputs: got %h required %h (state got %0d required %0d)",
                   trace.size(), got, r.v, got.state, r.v.state);
        else
          passes++;
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        if (cycle_cnt !== r.cyc[TB_CNT_W-1:0])
          $display("FAIL cycle%0d cycle_cnt: got %0d required %0d", trace.size(), cycle_cnt, r.cyc[TB_CNT_W-1:0]);
        else
          passes++;
        checks++;
        if (instret_cnt !== r.inst[TB_CNT_W-1:0])
          $display("FAIL cycle%0d instret_cnt: got %0d required %0d", trace.size(), instret_cnt, r.inst[TB_CNT_W-1:0]);
        else
          passes++;
        trace_inst.push_back(int'(instret_cnt));
`endif
        trace.push_back(got);
      end
      while (pin_q.size() > 0 && pin_q[0].idx < trace.size()) begin
        p   = pin_q.pop_front();
        act = (p.sel == SEL_INST) ? trace_inst[p.idx] : fld(trace[p.idx], p.sel);
        checks++;
        if (act != p.want)
          $display("FAIL pin %s: got %0d required %0d", p.name, act, p.want);
        else
          passes++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int s;
    vec_t v;
    srst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    opcode = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    @(posedge clk); #1;
    cyc(v_fetch(1'b1), 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(v_fetch(1'b1), 1'b1, 1'b0, 1'b1, 1'b0);
    pin("reset_state", 0, SEL_STATE, 0);
    pin("reset_ir_write", 0, SEL_IRW, 1);
    pin("reset_pc_write", 0, SEL_PCW, 1);
    pin("reset_alu_src_b", 0, SEL_SRCB, 2);
    pin("reset_illegal", 0, SEL_ILL, 0);

    // add: 0,1,6,8 then back to 0
    s = ncyc;
    run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("add_decode", s + 1, SEL_STATE, 1);
    pin("add_execr", s + 2, SEL_STATE, 6);
    pin("add_alu", s + 2, SEL_ALU, 0);
    pin("add_execr_regw", s + 2, SEL_REGW, 0);
    pin("add_aluwb", s + 3, SEL_STATE, 8);
    pin("add_aluwb_regw", s + 3, SEL_REGW, 1);
    // sub
    s = ncyc;
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
    pin("add_back_to_fetch", s, SEL_STATE, 0);
    pin("sub_alu", s + 2, SEL_ALU, 1);
    // addi with funct7b5=1 stays add; slti; or; and; sltu defaults to add
    s = ncyc;
    run_instr(IT, 3'b000, 1'b1, 1'b0, 1, 0);
    pin("addi_execi", s + 3, SEL_STATE, 7);
    pin("addi_alu", s + 3, SEL_ALU, 0);
    s = ncyc;
    run_instr(IT, 3'b010, 1'b0, 1'b0, 0, 0);
    pin("slti_alu", s + 2, SEL_ALU, 5);
    run_instr(RT, 3'b110, 1'b0, 1'b0, 0, 0);
    s = ncyc;
    pin("five_retired", s, SEL_STATE, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    pin("instret_after_5", s, SEL_INST, 5);
`endif
    run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0);
    pin("and_alu", s + 2, SEL_ALU, 2);
    run_instr(RT, 3'b011, 1'b0, 1'b0, 0, 0);

    // lw with 3 wait cycles in MEMREAD: 8 cycles total
    s = ncyc;
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 3);
    pin("lw_memread_last", s + 6, SEL_STATE, 3);
    pin("lw_memwb", s + 7, SEL_STATE, 4);
    pin("lw_memwb_result", s + 7, SEL_RES, 1);
    pin("lw_memwb_regw", s + 7, SEL_REGW, 1);
    // sw with fetch and write waits
    s = ncyc;
    run_instr(SW, 3'b010, 1'b0, 1'b0, 2, 2);
    pin("lw_total_8", s, SEL_STATE, 0);
    // beq taken / not taken
    s = ncyc;
    run_instr(BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    pin("beq_taken_state", s + 2, SEL_STATE, 9);
    pin("beq_taken_pcw", s + 2, SEL_PCW, 1);
    s = ncyc;
    run_instr(BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("beq_taken_3cyc", s, SEL_STATE, 0);
    pin("beq_not_taken_pcw", s + 2, SEL_PCW, 0);
    // jal
    s = ncyc;
    run_instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    pin("jal_state", s + 2, SEL_STATE, 10);
    pin("jal_pcw", s + 2, SEL_PCW, 1);
    pin("jal_aluwb", s + 3, SEL_STATE, 8);

    // illegal opcode: DECODE, then ILLEGAL for 10 cycles, then srst
    s = ncyc;
    opcode = BAD; funct3 = 3'b000; funct7b5 = 1'b0;
    cyc(v_fetch(1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    v = vbase(4'd1); v.alu_src_a = 2'b01; v.alu_src_b = 2'b01;
    cyc(v, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(v_ill(), i[0], 1'b1, 1'b0, 1'b0);
    cyc(v_ill(), 1'b1, 1'b0, 1'b1, 1'b0);
    pin("illegal_state", s + 2, SEL_STATE, 11);
    pin("illegal_flag", s + 11, SEL_ILL, 1);
    pin("illegal_no_pcw", s + 11, SEL_PCW, 0);
    s = ncyc;
    run_instr(IT, 3'b111, 1'b0, 1'b0, 0, 0);
    pin("after_srst_state", s, SEL_STATE, 0);
    pin("after_srst_illegal", s, SEL_ILL, 0);

    // srst in the middle of a MEMREAD wait
    opcode = LW;
    cyc(v_fetch(1'b1), 1'b1, 1'b0, 1'b0, 1'b0);
    v = vbase(4'd1); v.alu_src_a = 2'b01; v.alu_src_b = 2'b01;
    cyc(v, 1'b1, 1'b0, 1'b0, 1'b0);
    v = vbase(4'd2); v.alu_src_a = 2'b10; v.alu_src_b = 2'b01;
    cyc(v, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(v_mem(4'd3, 1'b0), 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(v_mem(4'd3, 1'b0), 1'b0, 1'b0, 1'b1, 1'b0);
    s = ncyc;
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 0);
    pin("midwait_srst_fetch", s, SEL_STATE, 0);
    for (int k = 0; k < 6; k++) run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
